// File: rtl/rng_arb_pkg.sv
// Shared types and helpers for the PRNG round-robin arbiter.
// Holds the FSM state type, default word width and the round-robin search function.
package rng_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSeed,
    StRun
  } state_e;

  localparam int unsigned RndWDefault = 5;
  localparam int unsigned MaxReq      = 8;
  localparam int unsigned MaxPtrW     = 3;

  typedef struct packed {
    logic               found;
    logic [MaxPtrW-1:0] idx;
  } rr_pick_t;

  // First set bit at index >= ptr, wrapping modulo n (n <= MaxReq).
  function automatic rr_pick_t rr_search(input logic [MaxReq-1:0]  req,
                                         input logic [MaxPtrW-1:0] ptr,
                                         input int unsigned        n);
    rr_pick_t r;
    r = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      logic [MaxPtrW-1:0] idx;
      idx = MaxPtrW'((32'(ptr) + k) % n);
      if ((k < n) && !r.found && req[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rng_arbiter_if.sv
// Consumer-facing draw bus of the PRNG arbiter.
// master = GA consumer side, slave = arbiter side.
interface rng_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RND_W   = 5
);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [2*RND_W-1:0] rnd_data;
  logic               ready;

  modport master (
    output req,
    input  gnt,
    input  rnd_data,
    input  ready
  );

  modport slave (
    input  req,
    output gnt,
    output rnd_data,
    output ready
  );

endinterface

// File: rtl/rng_arbiter_rr_picker.sv
// Combinational round-robin picker: request vector + pointer -> one-hot pick and next pointer.
// Reusable by any arbiter of up to eight requesters.
module rr_picker
  import rng_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned PtrW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PtrW-1:0]    rr_ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] pick,
  output logic [PtrW-1:0]    next_ptr
);

  rr_pick_t r;

  always_comb begin
    r        = rr_search(MaxReq'(req), MaxPtrW'(rr_ptr), NUM_REQ);
    any      = r.found;
    pick     = '0;
    next_ptr = '0;
    if (r.found) begin
      pick[r.idx[PtrW-1:0]] = 1'b1;
      next_ptr = (r.idx == MaxPtrW'(NUM_REQ - 1)) ? '0 : PtrW'(r.idx + 1'b1);
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Seeds the shared PRNG and hands out one fresh {random1, random0} pair per grant, round-robin.
// Optional draw counter output enabled by defining RNG_ARB_STATS_EN.
module rng_arbiter
  import rng_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WARMUP  = 8,
  parameter int unsigned RND_W   = RndWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [31:0]       seed_in,
  output logic [31:0]       prg_seed,
  input  logic [RND_W-1:0]  random0,
  input  logic [RND_W-1:0]  random1,
  rng_arbiter_if.slave      bus
`ifdef RNG_ARB_STATS_EN
  ,
  output logic [31:0]       draw_count
`endif
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [31:0]        seed_q, seed_d;
  logic               ready_q, ready_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [2*RND_W-1:0] rnd_q, rnd_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick;
  logic [PtrW-1:0]    pick_next_ptr;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req      (bus.req),
    .rr_ptr   (ptr_q),
    .any      (pick_any),
    .pick     (pick),
    .next_ptr (pick_next_ptr)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    ready_d = 1'b0;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    ptr_d   = ptr_q;
    // A seed load from any state restarts warm-up; any pending request is dropped.
    if (seed_load) begin
      seed_d  = seed_in;
      cnt_d   = CntW'(WARMUP - 1);
      state_d = StSeed;
    end else begin
      unique case (state_q)
        StIdle: ;
        StSeed: begin
          if (cnt_q == '0) begin
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        StRun: begin
          ready_d = 1'b1;
          if (pick_any) begin
            gnt_d = pick;
            rnd_d = {random1, random0};
            ptr_d = pick_next_ptr;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      seed_q  <= '0;
      ready_q <= 1'b0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
      ready_q <= ready_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      ptr_q   <= ptr_d;
    end
  end

  assign prg_seed     = seed_q;
  assign bus.gnt      = gnt_q;
  assign bus.rnd_data = rnd_q;
  assign bus.ready    = ready_q;

`ifdef RNG_ARB_STATS_EN
  logic [31:0] draw_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      draw_cnt_q <= '0;
    end else if (gnt_q != '0) begin
      draw_cnt_q <= draw_cnt_q + 32'd1;
    end
  end

  assign draw_count = draw_cnt_q;
`endif

endmodule

// File: tb/tb_rng_arbiter.sv
// Scoreboard bench for rng_arbiter: stimulus pushes expected grants, a negedge monitor checks them.
module tb_rng_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned RW = 5;
  localparam int unsigned WU = 8;

  typedef struct {
    logic [NR-1:0]   gnt;
    logic [2*RW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            seed_load;
  logic [31:0]     seed_in;
  logic [31:0]     prg_seed;
  logic [RW-1:0]   random0;
  logic [RW-1:0]   random1;
`ifdef RNG_ARB_STATS_EN
  logic [31:0]     draw_count;
`endif

  exp_t            sb_q[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int unsigned     seq      = 0;
  logic [2*RW-1:0] last_data;
  logic [NR-1:0]   rr_exp [5];

  rng_arbiter_if #(.NUM_REQ(NR), .RND_W(RW)) bus ();

  rng_arbiter #(
    .NUM_REQ (NR),
    .WARMUP  (WU),
    .RND_W   (RW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .prg_seed   (prg_seed),
    .random0    (random0),
    .random1    (random1),
    .bus        (bus)
`ifdef RNG_ARB_STATS_EN
    ,
    .draw_count (draw_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at a negedge, return at the following negedge.
  task automatic tick(input logic r_rst, input logic sl, input logic [31:0] sd,
                      input logic [NR-1:0] r, input logic [NR-1:0] exp_gnt);
    rst       = r_rst;
    seed_load = sl;
    seed_in   = sd;
    bus.req   = r;
    seq++;
    {random1, random0} = (2*RW)'(seq * 37 + 11);
    if (exp_gnt != '0) begin
      sb_q.push_back('{gnt: exp_gnt, data: {random1, random0}});
      last_data = {random1, random0};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: every presented grant must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.gnt != '0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: got gnt %0b expected none at %0t", bus.gnt, $time);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("grant_onehot", 64'(bus.gnt), 64'(e.gnt));
          chk("grant_data", 64'(bus.rnd_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    seed_load = 1'b0;
    seed_in   = '0;
    bus.req   = '0;
    random0   = '0;
    random1   = '0;
    last_data = '0;
    rr_exp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    @(negedge clk);

    // Reset
    tick(1'b1, 1'b0, 32'd0, '0, '0);
    tick(1'b1, 1'b0, 32'd0, 4'b1111, '0);
    chk("reset_gnt", 64'(bus.gnt), 64'd0);
    chk("reset_ready", 64'(bus.ready), 64'd0);
    chk("reset_prg_seed", 64'(prg_seed), 64'd0);
    chk("reset_rnd_data", 64'(bus.rnd_data), 64'd0);
`ifdef RNG_ARB_STATS_EN
    chk("reset_draw_count", 64'(draw_count), 64'd0);
`endif

    // Seed load and warm-up: ready rises WARMUP+1 edges after the pulse edge
    tick(1'b0, 1'b1, 32'd684135483, '0, '0);
    chk("seed_prg_seed", 64'(prg_seed), 64'd684135483);
    chk("seed_ready", 64'(bus.ready), 64'd0);
    for (int k = 1; k <= int'(WU); k++) begin
      tick(1'b0, 1'b0, 32'd0, 4'b1111, '0);
      chk("warm_ready", 64'(bus.ready), 64'd0);
      chk("warm_gnt", 64'(bus.gnt), 64'd0);
    end
    tick(1'b0, 1'b0, 32'd0, '0, '0);
    chk("ready_rise", 64'(bus.ready), 64'd1);
    chk("seed_held", 64'(prg_seed), 64'd684135483);

    // Round-robin from rr_ptr=0, then 1001 from rr_ptr=1
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'd0, 4'b1111, rr_exp[i]);
    tick(1'b0, 1'b0, 32'd0, 4'b1001, 4'b1000);
    tick(1'b0, 1'b0, 32'd0, 4'b1001, 4'b0001);
    tick(1'b0, 1'b0, 32'd0, '0, '0);
    chk("idle_gnt", 64'(bus.gnt), 64'd0);
    chk("idle_data_hold", 64'(bus.rnd_data), 64'(last_data));

    // Single held requester, then leave rr_ptr at 1
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'd0, 4'b0100, 4'b0100);
    tick(1'b0, 1'b0, 32'd0, 4'b0001, 4'b0001);
    tick(1'b0, 1'b0, 32'd0, '0, '0);

    // Reseed mid-run with requests pending
    tick(1'b0, 1'b1, 32'd1836248158, 4'b0011, '0);
    chk("reseed_gnt", 64'(bus.gnt), 64'd0);
    chk("reseed_ready", 64'(bus.ready), 64'd0);
    chk("reseed_prg_seed", 64'(prg_seed), 64'd1836248158);
    for (int k = 1; k <= int'(WU); k++) begin
      tick(1'b0, 1'b0, 32'd0, 4'b0011, '0);
      chk("reseed_warm_gnt", 64'(bus.gnt), 64'd0);
    end
    tick(1'b0, 1'b0, 32'd0, 4'b0011, 4'b0010);
    chk("reseed_ready_back", 64'(bus.ready), 64'd1);
    tick(1'b0, 1'b0, 32'd0, 4'b0011, 4'b0001);
    tick(1'b0, 1'b0, 32'd0, '0, '0);

    // Ten grants after a fresh seed
    tick(1'b0, 1'b1, 32'h1234_5678, '0, '0);
    for (int k = 1; k <= int'(WU); k++) tick(1'b0, 1'b0, 32'd0, '0, '0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'd0, 4'b0001, 4'b0001);
    tick(1'b0, 1'b0, 32'd0, '0, '0);
`ifdef RNG_ARB_STATS_EN
    chk("draw_count_10", 64'(draw_count), 64'd10);
`endif
    tick(1'b0, 1'b1, 32'hCAFE_F00D, '0, '0);
`ifdef RNG_ARB_STATS_EN
    chk("draw_count_clear", 64'(draw_count), 64'd0);
`endif
    chk("seed3_prg_seed", 64'(prg_seed), 64'hCAFE_F00D);

    // Reach RUN, then rst together with seed_load
    for (int k = 1; k <= int'(WU); k++) tick(1'b0, 1'b0, 32'd0, '0, '0);
    tick(1'b0, 1'b0, 32'd0, '0, '0);
    chk("run_again_ready", 64'(bus.ready), 64'd1);
    tick(1'b1, 1'b1, 32'h5555_AAAA, 4'b0011, '0);
    chk("rst_sl_prg_seed", 64'(prg_seed), 64'd0);
    chk("rst_sl_gnt", 64'(bus.gnt), 64'd0);
    chk("rst_sl_ready", 64'(bus.ready), 64'd0);
    chk("rst_sl_rnd_data", 64'(bus.rnd_data), 64'd0);
    tick(1'b0, 1'b0, 32'd0, 4'b1111, '0);
    tick(1'b0, 1'b0, 32'd0, 4'b1111, '0);
    chk("idle_ignores_req", 64'(bus.gnt), 64'd0);
    chk("idle_ready", 64'(bus.ready), 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
